// File: rtl/control_unit.sv
// K&S processor control unit: instruction-sequencing FSM, retired-instruction
// counter and sticky halt. Optional single-step mode under KS_SINGLE_STEP_EN.

package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

endpackage

module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
`ifdef KS_SINGLE_STEP_EN
    input  logic                    step_req,
`endif
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [15:0]             instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_LOAD_IR   = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_HALT      = 3'd4
`ifdef KS_SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 3'd5
`endif
    } state_t;

`ifdef KS_SINGLE_STEP_EN
    localparam state_t IDLE_STATE = S_STEP_WAIT;
`else
    localparam state_t IDLE_STATE = S_FETCH;
`endif

    state_t      state;
    state_t      next_state;
    logic        halt_q;
    logic [15:0] count_q;
    logic        take_branch;
    logic        is_mem_op;

    // No branch condition looks at signed overflow; kept on the port for symmetry.
    logic unused_signed_overflow;
    assign unused_signed_overflow = signed_overflow;

    assign is_mem_op = (decoded_instruction == I_LOAD) || (decoded_instruction == I_STORE);

    always_comb begin
        take_branch = 1'b0;
        case (decoded_instruction)
            I_BRANCH: take_branch = 1'b1;
            I_BZERO:  take_branch = zero_op;
            I_BNZERO: take_branch = ~zero_op;
            I_BNEG:   take_branch = neg_op;
            I_BNNEG:  take_branch = ~neg_op;
            I_BOV:    take_branch = unsigned_overflow;
            I_BNOV:   take_branch = ~unsigned_overflow;
            default:  take_branch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE_STATE;
            halt_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state <= next_state;
            if (state == S_DECODE && decoded_instruction == I_HALT) begin
                halt_q  <= 1'b1;
                count_q <= count_q + 16'd1;
            end else if (state == S_EXECUTE) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;

        case (state)
            S_FETCH: begin
                next_state = S_LOAD_IR;
            end

            S_LOAD_IR: begin
                ir_enable  = 1'b1;
                pc_enable  = 1'b1;
                next_state = S_DECODE;
            end

            S_DECODE: begin
                // Present the operand address a cycle early so the RAM read lands in EXECUTE.
                addr_sel   = is_mem_op;
                next_state = (decoded_instruction == I_HALT) ? S_HALT : S_EXECUTE;
            end

            S_EXECUTE: begin
                next_state = IDLE_STATE;
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        write_reg_enable = 1'b1;
                        flags_reg_enable = 1'b1;
                        case (decoded_instruction)
                            I_SUB:   operation = OP_SUB;
                            I_AND:   operation = OP_AND;
                            I_OR:    operation = OP_OR;
                            default: operation = OP_ADD;
                        endcase
                    end
                    I_MOVE: begin
                        operation        = OP_OR;
                        write_reg_enable = 1'b1;
                    end
                    I_LOAD: begin
                        addr_sel         = 1'b1;
                        c_sel            = 1'b1;
                        write_reg_enable = 1'b1;
                    end
                    I_STORE: begin
                        addr_sel         = 1'b1;
                        ram_write_enable = 1'b1;
                    end
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        branch    = take_branch;
                        pc_enable = take_branch;
                    end
                    default: ;
                endcase
            end

            S_HALT: begin
                next_state = S_HALT;
            end

`ifdef KS_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                next_state = step_req ? S_FETCH : S_STEP_WAIT;
            end
`endif

            default: next_state = IDLE_STATE;
        endcase
    end

    assign halt        = halt_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of per-instruction EXECUTE strobes plus
// hand sequences for mid-instruction reset, HALT and (with the macro) single-step.

module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable, ram_write_enable;
    logic                    halt;
    logic [15:0]             instr_count;
`ifdef KS_SINGLE_STEP_EN
    logic                    step_req;
`endif

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
`ifdef KS_SINGLE_STEP_EN
        .step_req            (step_req),
`endif
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt),
        .instr_count         (instr_count)
    );

    always #5 clk = ~clk;

    // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation, wr, flags, ram_we}
    logic [9:0] ctl;
    assign ctl = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                  write_reg_enable, flags_reg_enable, ram_write_enable};

    localparam logic [9:0] C_IDLE  = 10'b0000000000;
    localparam logic [9:0] C_LDIR  = 10'b0110000000;
    localparam logic [9:0] C_DMEM  = 10'b0001000000;
    localparam logic [9:0] C_TAKEN = 10'b1100000000;
    localparam logic [9:0] C_ADD   = 10'b0000000110;

    typedef struct {
        decoded_instruction_type instr;
        logic                    z, n, u, s;
        logic [9:0]              exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_count;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vecs[0]  = '{I_ADD,    1'b0, 1'b0, 1'b0, 1'b0, C_ADD};
        vecs[1]  = '{I_SUB,    1'b1, 1'b0, 1'b0, 1'b0, 10'b0000011110};
        vecs[2]  = '{I_AND,    1'b0, 1'b1, 1'b0, 1'b0, 10'b0000001110};
        vecs[3]  = '{I_OR,     1'b0, 1'b0, 1'b0, 1'b1, 10'b0000010110};
        vecs[4]  = '{I_MOVE,   1'b0, 1'b0, 1'b1, 1'b0, 10'b0000010100};
        vecs[5]  = '{I_LOAD,   1'b0, 1'b0, 1'b0, 1'b0, 10'b0001100100};
        vecs[6]  = '{I_STORE,  1'b0, 1'b0, 1'b0, 1'b0, 10'b0001000001};
        vecs[7]  = '{I_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, C_TAKEN};
        vecs[8]  = '{I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[9]  = '{I_BZERO,  1'b1, 1'b0, 1'b0, 1'b0, C_TAKEN};
        vecs[10] = '{I_BZERO,  1'b0, 1'b1, 1'b1, 1'b1, C_IDLE};
        vecs[11] = '{I_BNZERO, 1'b0, 1'b0, 1'b0, 1'b0, C_TAKEN};
        vecs[12] = '{I_BNZERO, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[13] = '{I_BNEG,   1'b0, 1'b1, 1'b0, 1'b0, C_TAKEN};
        vecs[14] = '{I_BNEG,   1'b1, 1'b0, 1'b1, 1'b1, C_IDLE};
        vecs[15] = '{I_BNNEG,  1'b0, 1'b0, 1'b0, 1'b0, C_TAKEN};
        vecs[16] = '{I_BNNEG,  1'b0, 1'b1, 1'b0, 1'b0, C_IDLE};
        vecs[17] = '{I_BOV,    1'b0, 1'b0, 1'b1, 1'b0, C_TAKEN};
        vecs[18] = '{I_BOV,    1'b1, 1'b1, 1'b0, 1'b1, C_IDLE};
        vecs[19] = '{I_BNOV,   1'b0, 1'b0, 1'b0, 1'b1, C_TAKEN};
        vecs[20] = '{I_BNOV,   1'b0, 1'b0, 1'b1, 1'b0, C_IDLE};
        vecs[21] = '{I_NOP,    1'b1, 1'b1, 1'b1, 1'b1, C_IDLE};

        rst_n               = 1'b0;
        decoded_instruction = I_NOP;
        zero_op             = 1'b0;
        neg_op              = 1'b0;
        unsigned_overflow   = 1'b0;
        signed_overflow     = 1'b0;
`ifdef KS_SINGLE_STEP_EN
        step_req            = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("reset_ctl", {6'd0, ctl}, 16'd0);
        chk("reset_halt", {15'd0, halt}, 16'd0);
        chk("reset_count", instr_count, 16'd0);
        rst_n     = 1'b1;
        exp_count = 16'd0;

        for (int i = 0; i < NV; i++) begin
`ifdef KS_SINGLE_STEP_EN
            chk("step_wait_ctl", {6'd0, ctl}, 16'd0);
            @(negedge clk);
`endif
            decoded_instruction = vecs[i].instr;
            zero_op             = vecs[i].z;
            neg_op              = vecs[i].n;
            unsigned_overflow   = vecs[i].u;
            signed_overflow     = vecs[i].s;
            chk($sformatf("v%0d_fetch_ctl", i), {6'd0, ctl}, 16'd0);
            chk($sformatf("v%0d_count", i), instr_count, exp_count);
            @(negedge clk);
            chk($sformatf("v%0d_load_ir_ctl", i), {6'd0, ctl}, {6'd0, C_LDIR});
            @(negedge clk);
            chk($sformatf("v%0d_decode_ctl", i), {6'd0, ctl},
                {6'd0, ((vecs[i].instr == I_LOAD || vecs[i].instr == I_STORE) ? C_DMEM : C_IDLE)});
            @(negedge clk);
            chk($sformatf("v%0d_exec_ctl", i), {6'd0, ctl}, {6'd0, vecs[i].exp});
            exp_count = exp_count + 16'd1;
            @(negedge clk);
        end

        // Asynchronous reset while in LOAD_IR of an ADD.
`ifdef KS_SINGLE_STEP_EN
        @(negedge clk);
`endif
        decoded_instruction = I_ADD;
        chk("pre_reset_count", instr_count, exp_count);
        @(negedge clk);
        chk("pre_reset_ldir", {6'd0, ctl}, {6'd0, C_LDIR});
        rst_n = 1'b0;
        #1;
        chk("midreset_ctl", {6'd0, ctl}, 16'd0);
        chk("midreset_count", instr_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef KS_SINGLE_STEP_EN
        chk("post_reset_step_wait", {6'd0, ctl}, 16'd0);
        @(negedge clk);
`endif
        chk("post_reset_fetch", {6'd0, ctl}, 16'd0);
        @(negedge clk);
        chk("post_reset_ldir", {6'd0, ctl}, {6'd0, C_LDIR});
        @(negedge clk);
        chk("post_reset_decode", {6'd0, ctl}, 16'd0);
        @(negedge clk);
        chk("post_reset_exec", {6'd0, ctl}, {6'd0, C_ADD});
        @(negedge clk);
        chk("post_reset_count", instr_count, 16'd1);

        // HALT from a fresh reset: sticky, strobes dead, counter frozen at 1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef KS_SINGLE_STEP_EN
        @(negedge clk);
`endif
        decoded_instruction = I_HALT;
        chk("halt_fetch_halt", {15'd0, halt}, 16'd0);
        @(negedge clk);
        chk("halt_ldir", {6'd0, ctl}, {6'd0, C_LDIR});
        @(negedge clk);
        chk("halt_decode_ctl", {6'd0, ctl}, 16'd0);
        chk("halt_decode_halt", {15'd0, halt}, 16'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            decoded_instruction = (c % 2 == 0) ? I_BRANCH : I_ADD;
            #1;
            chk($sformatf("halt_c%0d_halt", c), {15'd0, halt}, 16'd1);
            chk($sformatf("halt_c%0d_ctl", c), {6'd0, ctl}, 16'd0);
            chk($sformatf("halt_c%0d_count", c), instr_count, 16'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("halt_cleared", {15'd0, halt}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef KS_SINGLE_STEP_EN
        // One step_req pulse runs exactly one instruction.
        rst_n               = 1'b0;
        step_req            = 1'b0;
        decoded_instruction = I_ADD;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("step_idle_ctl", {6'd0, ctl}, 16'd0);
        end
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        chk("step_fetch", {6'd0, ctl}, 16'd0);
        @(negedge clk);
        chk("step_ldir", {6'd0, ctl}, {6'd0, C_LDIR});
        @(negedge clk);
        chk("step_decode", {6'd0, ctl}, 16'd0);
        @(negedge clk);
        chk("step_exec", {6'd0, ctl}, {6'd0, C_ADD});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("step_after_ctl", {6'd0, ctl}, 16'd0);
            chk("step_after_count", instr_count, 16'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the K&S processor. It is the counterpart of the data path across the control/status interface: it consumes `decoded_instruction` and the four flag registers, and drives every data-path and memory control strobe. It also keeps a retired-instruction counter and a sticky halt indication. It sits beside the data path inside the K&S top level and shares its clock, reset and synchronous single-port RAM.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `decoded_instruction` in `decoded_instruction_type` (k_and_s_pkg): current IR decode.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` in 1 each: registered ALU flags.
- `branch` out 1: PC loads the instruction address field instead of PC+1.
- `pc_enable` out 1: PC update strobe.
- `ir_enable` out 1: IR load strobe.
- `addr_sel` out 1: 0 selects PC for `ram_addr`; 1 selects the instruction address field.
- `c_sel` out 1: 0 writes ALU result; 1 writes `data_in` to the destination register.
- `operation` out 2: 00 ADD, 01 AND, 10 OR, 11 SUB.
- `write_reg_enable` out 1: register-file write strobe.
- `flags_reg_enable` out 1: flag-register load strobe.
- `ram_write_enable` out 1: RAM write strobe.
- `halt` out 1: sticky, set by HALT.
- `instr_count` out 16: retired-instruction count.
- `step_req` in 1: present only with `KS_SINGLE_STEP_EN`.

## Operation
- States and transitions:
  - FETCH → LOAD_IR → DECODE → EXECUTE → FETCH.
  - HALT has no exit except reset.
  - STEP_WAIT exists only with the macro; see Configuration.
- FETCH: all strobes 0, `addr_sel`=0. The RAM registers the read of `mem[PC]`.
- LOAD_IR: `ir_enable`=1, `pc_enable`=1, `branch`=0, `addr_sel`=0. At the edge, the IR captures `data_in` and PC becomes PC+1, wrapping 31→0.
- DECODE: `addr_sel`=1 for LOAD and STORE, otherwise 0. All other strobes are 0. The register-file read ports capture their operands at this edge. If the decode is HALT, the next state is HALT and the count increments.
- EXECUTE outputs by instruction:
  - ADD, SUB, AND, OR: `operation` is 00, 11, 01, 10 respectively; `c_sel`=0, `write_reg_enable`=1, `flags_reg_enable`=1.
  - MOVE: `operation`=10 (source OR itself), `c_sel`=0, `write_reg_enable`=1, `flags_reg_enable`=0.
  - LOAD: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1.
  - STORE: `addr_sel`=1, `ram_write_enable`=1.
  - BRANCH: `branch`=1, `pc_enable`=1.
  - Conditional branches: `branch`=1 and `pc_enable`=1 only when the condition is true. Otherwise all strobes are 0 and PC keeps the already-incremented value.
  - NOP: all strobes 0.
- Branch conditions are evaluated from the flag registers as they stand in EXECUTE:
  - BZERO: `zero_op`=1. BNZERO: `zero_op`=0.
  - BNEG: `neg_op`=1. BNNEG: `neg_op`=0.
  - BOV: `unsigned_overflow`=1. BNOV: `unsigned_overflow`=0.
- `signed_overflow` is observed but no branch uses it.
- `instr_count`:
  - Increments by 1 at the EXECUTE→next edge, and at the DECODE→HALT edge.
  - Wraps modulo 2^16.
  - Never increments in HALT.
- Strobe outputs are combinational from the state register and `decoded_instruction` (Moore-style per state). Only the state, `halt` and `instr_count` are registers.

## Timing
- Reset (asynchronous, mid-instruction included):
  - State goes to FETCH (STEP_WAIT with the macro).
  - `halt`=0, `instr_count`=0, all strobes 0, `operation`=00.
  - Any pending write is dropped.
- Every non-HALT instruction takes exactly 4 cycles. HALT takes 3 cycles to reach the HALT state.
- `halt` rises on the first cycle in HALT. In HALT all strobes are held 0.
- A taken branch fetches from the target in the very next FETCH.
- Flags written by instruction N are visible to a branch at N+1. There is no forwarding hazard.

## Configuration
- `KS_SINGLE_STEP_EN` defined:
  - Adds the `step_req` port and the STEP_WAIT state, which is the reset state.
  - STEP_WAIT holds all strobes 0 and moves to FETCH on the first cycle `step_req`=1.
  - EXECUTE returns to STEP_WAIT instead of FETCH.
  - `step_req` held high runs continuously, with 5 cycles per instruction.
- `KS_SINGLE_STEP_EN` undefined: no port and no state. EXECUTE goes directly to FETCH.

## Test plan
- Reset mid-LOAD_IR (assert `rst_n`=0 in cycle 2) → next cycle all strobes 0, `instr_count`=0, state FETCH.
- ADD in IR, flags 0 → EXECUTE shows `operation`=00, `write_reg_enable`=1, `flags_reg_enable`=1; `instr_count` goes 0→1 after 4 cycles.
- LOAD then STORE → LOAD EXECUTE has `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1; STORE EXECUTE has `ram_write_enable`=1 and `write_reg_enable`=0.
- BZERO with `zero_op`=1 → `branch`=1 and `pc_enable`=1 in EXECUTE. Repeat with `zero_op`=0 → both 0. Repeat for BNEG, BNNEG, BOV, BNOV, BNZERO with both flag values.
- HALT → `halt`=1 from cycle 4 onward for 20 cycles; all strobes 0; `instr_count` frozen at 1.
- With `KS_SINGLE_STEP_EN`, `step_req` pulsed once → exactly one instruction executes, then the FSM idles in STEP_WAIT; `instr_count`=1.
